gf180mcu_fd_sc_mcu7t5v0__aoi21_selftest: RTL and testbench

Single-clock sequencer that checks an aoi21 cell instance on silicon. It sits on both sides of the cell: it drives the A1, A2 and B inputs with all eight input combinations, and it captures the cell's ZN output. Each captured ZN is compared against ZN = !((A1 & A2) | B). The block reports pass/fail, a saturating error count and the first failing vector to the characterization/scan controller.

---
 rtl/gf180mcu_fd_sc_mcu7t5v0__aoi21_selftest.sv | 126 ++++++++++++
 tb/tb_gf180mcu_fd_sc_mcu7t5v0__aoi21_selftest.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__aoi21_selftest.sv
// Self-test sequencer for one aoi21 cell: applies all eight input vectors,
// samples ZN after a settle window, and reports pass/fail, error count and first failing vector.
module gf180mcu_fd_sc_mcu7t5v0__aoi21_selftest #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned LOOPS         = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       ZN,
  output logic       A1,
  output logic       A2,
  output logic       B,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [7:0] ERR_CNT,
  output logic [2:0] FAIL_VEC,
  inout  wire        VDD,
  inout  wire        VSS
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] LOOP_LAST   = 8'(LOOPS - 1);
  // Expected ZN indexed by {A1,A2,B}: ZN = !((A1 & A2) | B).
  localparam logic [7:0] AOI21_TRUTH = 8'b0001_0101;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] vec;
  logic [7:0] settle_cnt;
  logic [7:0] loop_cnt;
  logic       first_fail;
  logic [7:0] err_cnt;
  logic [2:0] fail_vec;
  logic       exp_zn;
  logic       mismatch;
  logic       last_vec;
  logic       unused_supply;

  // Supplies are pass-through for the cell; nothing in the logic consumes them.
  assign unused_supply = VDD ^ VSS;

  assign exp_zn   = AOI21_TRUTH[vec];
  // Case-inequality so an X or Z on the cell output is treated as a failure.
  assign mismatch = (ZN !== exp_zn);
  assign last_vec = (vec == 3'd7) && (loop_cnt >= LOOP_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (START) state_nxt = S_SETTLE;
      S_SETTLE:       if (settle_cnt == SETTLE_LAST) state_nxt = S_SAMPLE;
      S_SAMPLE:       state_nxt = last_vec ? S_DONE : S_SETTLE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      vec        <= 3'd0;
      settle_cnt <= 8'd0;
      loop_cnt   <= 8'd0;
      first_fail <= 1'b0;
      err_cnt    <= 8'd0;
      fail_vec   <= 3'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (START) begin
            vec        <= 3'd0;
            settle_cnt <= 8'd0;
            loop_cnt   <= 8'd0;
            first_fail <= 1'b0;
            err_cnt    <= 8'd0;
            fail_vec   <= 3'd0;
          end
        end
        S_SETTLE: begin
          settle_cnt <= (settle_cnt == SETTLE_LAST) ? 8'd0 : settle_cnt + 8'd1;
        end
        S_SAMPLE: begin
          settle_cnt <= 8'd0;
          if (mismatch) begin
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            if (!first_fail) begin
              first_fail <= 1'b1;
              fail_vec   <= vec;
            end
          end
          // The final vector stays on the cell pins once the run is done.
          if (!last_vec) begin
            vec <= vec + 3'd1;
            if (vec == 3'd7) loop_cnt <= loop_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    {A1, A2, B} = vec;
    BUSY        = (state == S_SETTLE) || (state == S_SAMPLE);
    DONE        = (state == S_DONE);
    PASS        = (state == S_DONE) && (err_cnt == 8'd0);
    ERR_CNT     = err_cnt;
    FAIL_VEC    = fail_vec;
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__aoi21_selftest.sv
// Directed bench for the aoi21 self-test sequencer; a behavioural cell model
// (ideal / stuck-at-0 / stuck-at-1) drives ZN and a scoreboard holds expected run results.
module tb_gf180mcu_fd_sc_mcu7t5v0__aoi21_selftest;

  typedef struct {
    logic [7:0] err;
    logic [2:0] fvec;
    logic       pass;
    int         cycles;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start2;
  logic       zn, zn2;
  logic       a1, a2, b, busy, done, pass;
  logic [7:0] err_cnt;
  logic [2:0] fail_vec;
  logic       a1_2, a2_2, b_2, busy2, done2, pass2;
  logic [7:0] err_cnt2;
  logic [2:0] fail_vec2;
  wire        vdd = 1'b1;
  wire        vss = 1'b0;
  int         mode;
  int         checks = 0;
  int         errors = 0;
  exp_t       sb[$];

  always #5 clk = ~clk;

  // Cell model: 0 = ideal aoi21, 1 = stuck-at-0, 2 = stuck-at-1.
  always_comb begin
    zn = 1'b0;
    case (mode)
      0:       zn = ~((a1 & a2) | b);
      1:       zn = 1'b0;
      default: zn = 1'b1;
    endcase
  end
  assign zn2 = 1'b0;

  gf180mcu_fd_sc_mcu7t5v0__aoi21_selftest dut (
    .CLK(clk), .RST(rst), .START(start), .ZN(zn),
    .A1(a1), .A2(a2), .B(b), .BUSY(busy), .DONE(done), .PASS(pass),
    .ERR_CNT(err_cnt), .FAIL_VEC(fail_vec), .VDD(vdd), .VSS(vss)
  );

  gf180mcu_fd_sc_mcu7t5v0__aoi21_selftest #(.SETTLE_CYCLES(1), .LOOPS(100)) dut_loop (
    .CLK(clk), .RST(rst), .START(start2), .ZN(zn2),
    .A1(a1_2), .A2(a2_2), .B(b_2), .BUSY(busy2), .DONE(done2), .PASS(pass2),
    .ERR_CNT(err_cnt2), .FAIL_VEC(fail_vec2), .VDD(vdd), .VSS(vss)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Expected outcome of one run with the cell model in the given mode.
  function automatic exp_t model(input int m, input int loops, input int settle);
    exp_t e;
    int   cnt = 0;
    bit   seen = 0;
    e.fvec = 3'd0;
    for (int l = 0; l < loops; l++) begin
      for (int v = 0; v < 8; v++) begin
        logic ideal, got;
        ideal = !(((v >> 2) & (v >> 1) & 1) != 0 || (v & 1) != 0);
        got   = (m == 0) ? ideal : (m == 1) ? 1'b0 : 1'b1;
        if (got != ideal) begin
          cnt++;
          if (!seen) begin
            seen   = 1;
            e.fvec = 3'(v);
          end
        end
      end
    end
    e.err    = (cnt > 255) ? 8'hFF : 8'(cnt);
    e.pass   = (cnt == 0);
    e.cycles = 8 * loops * (settle + 1);
    return e;
  endfunction

  task automatic start_run(input string tag);
    sb.push_back(model(mode, 1, 2));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_done_low"}, done, 0);
    chk({tag, "_vec0"}, {a1, a2, b}, 0);
    chk({tag, "_err0"}, err_cnt, 0);
  endtask

  task automatic wait_done(input string tag, input bit mid_pulse, input int n0);
    int   n = n0;
    exp_t e;
    while (!done && n < 4000) begin
      if (mid_pulse && n == 10) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb: observed empty scoreboard expected one entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_cycles"}, n, e.cycles);
      chk({tag, "_done"}, done, 1);
      chk({tag, "_busy_low"}, busy, 0);
      chk({tag, "_err_cnt"}, err_cnt, e.err);
      chk({tag, "_fail_vec"}, fail_vec, e.fvec);
      chk({tag, "_pass"}, pass, e.pass);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; start2 = 1'b0; mode = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vec", {a1, a2, b}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_fvec", fail_vec, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    mode = 0; start_run("ideal"); wait_done("ideal", 0, 0);
    mode = 1; start_run("sa0");   wait_done("sa0", 0, 0);
    mode = 2; start_run("sa1");   wait_done("sa1", 0, 0);

    // START pulsed mid-run must not disturb the run.
    mode = 1; start_run("midstart"); wait_done("midstart", 1, 0);

    // START held across DONE restarts at once; the second high cycle is ignored.
    mode = 0;
    sb.push_back(model(mode, 1, 2));
    start = 1'b1;
    @(posedge clk); #1;
    chk("hold_done_drop", done, 0);
    chk("hold_busy", busy, 1);
    chk("hold_err_clr", err_cnt, 0);
    chk("hold_fvec_clr", fail_vec, 0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("hold_ignored_vec", {a1, a2, b}, 0);
    wait_done("hold", 0, 1);

    // Reset during SETTLE of vector 5, then a fresh run.
    mode = 1; start_run("pre_rst");
    n = 0;
    while ({a1, a2, b} != 3'd5 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_vec5", {a1, a2, b}, 5);
    chk("vec5_err_before_rst", err_cnt, 3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    chk("midrst_vec", {a1, a2, b}, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_err", err_cnt, 0);
    chk("midrst_fvec", fail_vec, 0);
    start_run("post_rst"); wait_done("post_rst", 0, 0);

    // Long run with saturating error count.
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    chk("loop_busy", busy2, 1);
    n = 0;
    while (!done2 && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("loop_cycles", n, model(1, 100, 1).cycles);
    chk("loop_err_sat", err_cnt2, model(1, 100, 1).err);
    chk("loop_fvec", fail_vec2, 0);
    chk("loop_pass", pass2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
